// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: serial FSM state encoding and
// the supported operand width range.
package arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of the bit-serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;
    logic             zero;

    modport master (
        output start, a, b, borrow_in,
        input  busy, done, diff, borrow, ovf, zero
    );

    modport slave (
        input  start, a, b, borrow_in,
        output busy, done, diff, borrow, ovf, zero
    );
endinterface

// File: rtl/serial_subtractor_cell.sv
// Gate-level full subtractor: two half-subtractor stages whose borrows are ORed.
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
    logic d1, b1, b2;

    assign d1   = a ^ b;
    assign b1   = ~a & b;
    assign diff = d1 ^ bin;
    assign b2   = ~d1 & bin;
    assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell, LSB first,
// one bit per clock, results published with a one-cycle done pulse.
module serial_subtractor
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("serial_subtractor: WIDTH out of range");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] pd_q, pd_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic cell_d, cell_bo;

    full_subtractor_cell u_cell (
        .a    (sa_q[0]),
        .b    (sb_q[0]),
        .bin  (br_q),
        .diff (cell_d),
        .bout (cell_bo)
    );

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        pd_d     = pd_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = bus.borrow_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = cell_bo;
                pd_d  = {cell_d, pd_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // On the last step sa/sb bit 0 are the operand sign bits.
                    state_d  = DONE;
                    diff_d   = pd_d;
                    borrow_d = cell_bo;
                    zero_d   = (pd_d == '0);
                    ovf_d    = (sa_q[0] ^ sb_q[0]) & (sa_q[0] ^ cell_d);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            pd_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            pd_q     <= pd_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
    assign bus.ovf    = ovf_q;
    assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and an exhaustive WIDTH=2 sweep.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(2)) if2 ();

    serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_subtractor #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb, input logic eo, input logic ez,
                        input logic [7:0] held);
        int n;
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.borrow_in = bin;
        tick();
        if8.start = 1'b0; if8.a = ~a; if8.b = ~b; if8.borrow_in = ~bin;
        check({tag, "_busy"}, 64'(if8.busy), 64'd1);
        check({tag, "_hold"}, 64'(if8.diff), 64'(held));
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (if8.done) begin n = i; break; end
        end
        check({tag, "_lat"}, 64'(n), 64'd8);
        check({tag, "_diff"}, 64'(if8.diff), 64'(ed));
        check({tag, "_borrow"}, 64'(if8.borrow), 64'(eb));
        check({tag, "_ovf"}, 64'(if8.ovf), 64'(eo));
        check({tag, "_zero"}, 64'(if8.zero), 64'(ez));
        check({tag, "_busy_done"}, 64'(if8.busy), 64'd0);
        tick();
        check({tag, "_pulse"}, 64'(if8.done), 64'd0);
    endtask

    task automatic run2(input string tag, input logic [1:0] a, input logic [1:0] b, input logic bin,
                        input logic [1:0] ed, input logic eb, input logic eo, input logic ez);
        int n;
        if2.start = 1'b1; if2.a = a; if2.b = b; if2.borrow_in = bin;
        tick();
        if2.start = 1'b0; if2.a = ~a; if2.b = ~b;
        n = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (if2.done) begin n = i; break; end
        end
        check({tag, "_lat"}, 64'(n), 64'd2);
        check({tag, "_diff"}, 64'(if2.diff), 64'(ed));
        check({tag, "_borrow"}, 64'(if2.borrow), 64'(eb));
        check({tag, "_ovf"}, 64'(if2.ovf), 64'(eo));
        check({tag, "_zero"}, 64'(if2.zero), 64'(ez));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, d2, seen;
        rst = 1'b1;
        if8.start = 1'b1; if8.a = 8'h11; if8.b = 8'h22; if8.borrow_in = 1'b0;
        if2.start = 1'b1; if2.a = 2'd1;  if2.b = 2'd2;  if2.borrow_in = 1'b0;
        tick();
        tick();
        check("rst_busy8", 64'(if8.busy), 64'd0);
        check("rst_done8", 64'(if8.done), 64'd0);
        check("rst_diff8", 64'(if8.diff), 64'd0);
        check("rst_borrow8", 64'(if8.borrow), 64'd0);
        check("rst_ovf8", 64'(if8.ovf), 64'd0);
        check("rst_zero8", 64'(if8.zero), 64'd0);
        check("rst_busy2", 64'(if2.busy), 64'd0);
        rst = 1'b0;
        if8.start = 1'b0;
        if2.start = 1'b0;
        tick();

        run8("t1", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 8'h00);
        run8("t2", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0, 8'h02);
        run8("t3", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 8'hFE);
        run8("t4", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h7F);

        // start held high: mid-run start/operand changes ignored, back-to-back at DONE
        if8.start = 1'b1; if8.a = 8'h05; if8.b = 8'h03; if8.borrow_in = 1'b0;
        tick();
        if8.a = 8'h80; if8.b = 8'h01;
        d1 = 0; d2 = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (if8.done) begin
                if (d1 == 0) begin
                    d1 = i;
                    check("b2b_diff1", 64'(if8.diff), 64'h02);
                end else begin
                    d2 = i;
                    check("b2b_diff2", 64'(if8.diff), 64'h7F);
                    check("b2b_ovf2", 64'(if8.ovf), 64'd1);
                    if8.start = 1'b0;
                    break;
                end
            end
        end
        if8.start = 1'b0;
        check("b2b_first", 64'(d1), 64'd8);
        check("b2b_gap", 64'(d2 - d1), 64'd9);
        tick();
        check("b2b_idle", 64'(if8.done), 64'd0);

        // reset during RUN aborts without a done pulse
        if8.start = 1'b1; if8.a = 8'h5A; if8.b = 8'h01; if8.borrow_in = 1'b0;
        tick();
        if8.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("abort_busy_pre", 64'(if8.busy), 64'd1);
        rst = 1'b1;
        tick();
        check("abort_busy", 64'(if8.busy), 64'd0);
        check("abort_done", 64'(if8.done), 64'd0);
        check("abort_diff", 64'(if8.diff), 64'd0);
        check("abort_borrow", 64'(if8.borrow), 64'd0);
        check("abort_ovf", 64'(if8.ovf), 64'd0);
        check("abort_zero", 64'(if8.zero), 64'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (if8.done || if8.busy) seen++;
        end
        check("abort_quiet", 64'(seen), 64'd0);

        run8("t5", 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00);

        for (int ai = 0; ai < 4; ai++) begin
            for (int bi = 0; bi < 4; bi++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    int r, sa, sb, sr;
                    logic [1:0] ed;
                    logic eb, eo, ez;
                    r  = ai - bi - ci;
                    ed = 2'(r & 3);
                    eb = (ai < bi + ci);
                    sa = (ai >= 2) ? ai - 4 : ai;
                    sb = (bi >= 2) ? bi - 4 : bi;
                    sr = sa - sb - ci;
                    eo = (sr < -2) || (sr > 1);
                    ez = (ed == 2'd0);
                    run2($sformatf("w2_%0d_%0d_%0d", ai, bi, ci), 2'(ai), 2'(bi), 1'(ci), ed, eb, eo, ez);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
